// File: rtl/mem_stage.sv
// -----------------------------------------------------------------------------
// mem_stage -- memory-access pipeline stage.
//
// Holds one instruction handed over from EX, merges the synchronous SRAM read
// data into the register-file write value (with byte/halfword extension), and
// offers the result to WB. A load that stalls in MEM keeps the SRAM data it saw
// in its first cycle, because the SRAM output is only valid for that one cycle.
//
// Ports:
//   clk              in   1    rising-edge clock
//   resetn           in   1    asynchronous active-low reset
//   ex_to_mem_valid  in   1    EX offers an instruction
//   ex_to_mem_bus    in   157  EX payload (pc, load control, rf/csr fields)
//   mem_allowin      out  1    MEM can accept from EX this cycle
//   data_sram_rdata  in   32   SRAM read data, valid the cycle after issue
//   wb_allowin       in   1    WB can accept
//   mem_to_wb_valid  out  1    MEM offers an instruction to WB
//   mem_to_wb_bus    out  151  result payload towards WB
//   mem_to_id_bus    out  39   forwarding/hazard info towards ID
//   ertn_flush       in   1    pipeline flush from WB
// -----------------------------------------------------------------------------
module mem_stage (
  input  logic         clk,
  input  logic         resetn,
  input  logic         ex_to_mem_valid,
  input  logic [156:0] ex_to_mem_bus,
  output logic         mem_allowin,
  input  logic [31:0]  data_sram_rdata,
  input  logic         wb_allowin,
  output logic         mem_to_wb_valid,
  output logic [150:0] mem_to_wb_bus,
  output logic [38:0]  mem_to_id_bus,
  input  logic         ertn_flush
);

  logic         mem_valid_r;
  logic [156:0] payload_r;
  logic [31:0]  rdata_hold_r;
  logic         hold_r;

  logic         mem_ready_go_s;
  logic [31:0]  pc_s;
  logic         res_from_mem_s;
  logic         rf_we_s;
  logic [4:0]   rf_waddr_s;
  logic [31:0]  alu_result_s;
  logic [31:0]  rkd_value_s;
  logic [1:0]   addr_lo_s;
  logic         op_b_s;
  logic         op_h_s;
  logic         op_u_s;
  logic         csr_re_s;
  logic         csr_we_s;
  logic [13:0]  csr_num_s;
  logic [31:0]  csr_wmask_s;
  logic         ertn_s;

  logic [31:0]  load_rdata_s;
  logic [31:0]  byte_src_s;
  logic [15:0]  half_src_s;
  logic [31:0]  load_value_s;
  logic [31:0]  rf_wdata_s;

  assign pc_s           = payload_r[156:125];
  assign res_from_mem_s = payload_r[124];
  assign rf_we_s        = payload_r[123];
  assign rf_waddr_s     = payload_r[122:118];
  assign alu_result_s   = payload_r[117:86];
  assign rkd_value_s    = payload_r[85:54];
  assign addr_lo_s      = payload_r[53:52];
  assign op_b_s         = payload_r[51];
  assign op_h_s         = payload_r[50];
  assign op_u_s         = payload_r[49];
  assign csr_re_s       = payload_r[48];
  assign csr_we_s       = payload_r[47];
  assign csr_num_s      = payload_r[46:33];
  assign csr_wmask_s    = payload_r[32:1];
  assign ertn_s         = payload_r[0];

  assign mem_ready_go_s  = 1'b1;
  assign mem_allowin     = ~mem_valid_r | (mem_ready_go_s & wb_allowin);
  assign mem_to_wb_valid = mem_valid_r & mem_ready_go_s;

  // Stage occupancy: flush wins over a simultaneous handoff from EX.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      mem_valid_r <= 1'b0;
    end else if (ertn_flush) begin
      mem_valid_r <= 1'b0;
    end else if (mem_allowin) begin
      mem_valid_r <= ex_to_mem_valid;
    end else begin
      mem_valid_r <= mem_valid_r;
    end
  end

  // Payload register: only a real handoff overwrites it.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      payload_r <= 157'd0;
    end else if (ex_to_mem_valid && mem_allowin) begin
      payload_r <= ex_to_mem_bus;
    end else begin
      payload_r <= payload_r;
    end
  end

  // Read-data capture: keep the first-cycle SRAM word while the stage stalls.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      hold_r       <= 1'b0;
      rdata_hold_r <= 32'd0;
    end else if (ertn_flush) begin
      hold_r       <= 1'b0;
      rdata_hold_r <= rdata_hold_r;
    end else if (mem_valid_r && !hold_r && !wb_allowin) begin
      // First cycle of a stalled instruction: SRAM output is about to go stale.
      hold_r       <= 1'b1;
      rdata_hold_r <= data_sram_rdata;
    end else if (wb_allowin) begin
      // Instruction leaves (or stage idle); the next one reads the SRAM live.
      hold_r       <= 1'b0;
      rdata_hold_r <= rdata_hold_r;
    end else begin
      hold_r       <= hold_r;
      rdata_hold_r <= rdata_hold_r;
    end
  end

  assign load_rdata_s = hold_r ? rdata_hold_r : data_sram_rdata;
  assign byte_src_s   = load_rdata_s >> {addr_lo_s, 3'b000};
  assign half_src_s   = addr_lo_s[1] ? load_rdata_s[31:16] : load_rdata_s[15:0];

  // Load extension by access size and signedness.
  always_comb begin
    load_value_s = load_rdata_s;
    if (op_b_s) begin
      if (op_u_s) begin
        load_value_s = {24'd0, byte_src_s[7:0]};
      end else begin
        load_value_s = {{24{byte_src_s[7]}}, byte_src_s[7:0]};
      end
    end else if (op_h_s) begin
      if (op_u_s) begin
        load_value_s = {16'd0, half_src_s};
      end else begin
        load_value_s = {{16{half_src_s[15]}}, half_src_s};
      end
    end else begin
      load_value_s = load_rdata_s;
    end
  end

  assign rf_wdata_s = res_from_mem_s ? load_value_s : alu_result_s;

  assign mem_to_wb_bus = {pc_s,
                          rf_we_s & mem_valid_r,
                          rf_waddr_s,
                          rf_wdata_s,
                          csr_re_s & mem_valid_r,
                          csr_we_s,
                          csr_num_s,
                          csr_wmask_s,
                          rkd_value_s,
                          ertn_s & mem_valid_r};

  assign mem_to_id_bus = {rf_we_s & mem_valid_r,
                          rf_waddr_s,
                          rf_wdata_s,
                          csr_re_s & mem_valid_r};

endmodule

// File: tb/tb_mem_stage.sv
module tb_mem_stage;

  logic         clk;
  logic         resetn;
  logic         ex_to_mem_valid;
  logic [156:0] ex_to_mem_bus;
  logic         mem_allowin;
  logic [31:0]  data_sram_rdata;
  logic         wb_allowin;
  logic         mem_to_wb_valid;
  logic [150:0] mem_to_wb_bus;
  logic [38:0]  mem_to_id_bus;
  logic         ertn_flush;

  int n_checks = 0;
  int n_fail   = 0;
  logic [150:0] sb[$];

  mem_stage dut (
    .clk             (clk),
    .resetn          (resetn),
    .ex_to_mem_valid (ex_to_mem_valid),
    .ex_to_mem_bus   (ex_to_mem_bus),
    .mem_allowin     (mem_allowin),
    .data_sram_rdata (data_sram_rdata),
    .wb_allowin      (wb_allowin),
    .mem_to_wb_valid (mem_to_wb_valid),
    .mem_to_wb_bus   (mem_to_wb_bus),
    .mem_to_id_bus   (mem_to_id_bus),
    .ertn_flush      (ertn_flush)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [156:0] mk_ex(
      input logic [31:0] pc, input logic rfm, input logic we, input logic [4:0] wa,
      input logic [31:0] alu, input logic [31:0] rkd, input logic [1:0] lo,
      input logic b, input logic h, input logic u, input logic cre, input logic cwe,
      input logic [13:0] cnum, input logic [31:0] cmask, input logic ert);
    return {pc, rfm, we, wa, alu, rkd, lo, b, h, u, cre, cwe, cnum, cmask, ert};
  endfunction

  function automatic logic [150:0] mk_wb(
      input logic [31:0] pc, input logic we, input logic [4:0] wa, input logic [31:0] wd,
      input logic cre, input logic cwe, input logic [13:0] cnum, input logic [31:0] cmask,
      input logic [31:0] cwd, input logic ert);
    return {pc, we, wa, wd, cre, cwe, cnum, cmask, cwd, ert};
  endfunction

  // Present one instruction from EX (called just after a rising edge).
  task automatic issue(input logic [156:0] b);
    ex_to_mem_valid = 1'b1;
    ex_to_mem_bus   = b;
    @(posedge clk); #1;
    ex_to_mem_valid = 1'b0;
  endtask

  task automatic test_reset;
    #2;
    n_checks++;
    if (mem_allowin !== 1'b1) begin n_fail++; $display("FAIL reset_allowin: got %b expected 1", mem_allowin); end
    n_checks++;
    if (mem_to_wb_valid !== 1'b0) begin n_fail++; $display("FAIL reset_wb_valid: got %b expected 0", mem_to_wb_valid); end
    n_checks++;
    if (mem_to_wb_bus !== 151'd0) begin n_fail++; $display("FAIL reset_wb_bus: got %h expected 0", mem_to_wb_bus); end
    n_checks++;
    if (mem_to_id_bus !== 39'd0) begin n_fail++; $display("FAIL reset_id_bus: got %h expected 0", mem_to_id_bus); end
    repeat (2) @(posedge clk);
    #1 resetn = 1'b1;
  endtask

  task automatic test_load_ext;
    logic [31:0] rd  [6];
    logic [1:0]  lo  [6];
    logic        b   [6];
    logic        h   [6];
    logic        u   [6];
    logic [31:0] exp [6];
    logic [31:0] pc;
    logic [150:0] e;
    rd[0] = 32'h12F45678; lo[0] = 2'd2; b[0] = 1'b1; h[0] = 1'b0; u[0] = 1'b0; exp[0] = 32'hFFFFFFF4;
    rd[1] = 32'h12F45678; lo[1] = 2'd2; b[1] = 1'b1; h[1] = 1'b0; u[1] = 1'b1; exp[1] = 32'h000000F4;
    rd[2] = 32'h80017FFF; lo[2] = 2'd2; b[2] = 1'b0; h[2] = 1'b1; u[2] = 1'b0; exp[2] = 32'hFFFF8001;
    rd[3] = 32'h80017FFF; lo[3] = 2'd0; b[3] = 1'b0; h[3] = 1'b0; u[3] = 1'b0; exp[3] = 32'h80017FFF;
    rd[4] = 32'h80017FFF; lo[4] = 2'd2; b[4] = 1'b0; h[4] = 1'b1; u[4] = 1'b1; exp[4] = 32'h00008001;
    rd[5] = 32'h12F45678; lo[5] = 2'd0; b[5] = 1'b1; h[5] = 1'b0; u[5] = 1'b0; exp[5] = 32'h00000078;
    wb_allowin = 1'b1;
    for (int i = 0; i < 6; i++) begin
      pc = 32'h1C000100 + 32'(i * 4);
      sb.push_back(mk_wb(pc, 1'b1, 5'(i + 1), exp[i], 1'b0, 1'b0, 14'd0, 32'd0, 32'd0, 1'b0));
      issue(mk_ex(pc, 1'b1, 1'b1, 5'(i + 1), {30'h04000000, lo[i]}, 32'd0, lo[i],
                  b[i], h[i], u[i], 1'b0, 1'b0, 14'd0, 32'd0, 1'b0));
      data_sram_rdata = rd[i];
      @(negedge clk);
      n_checks++;
      if (mem_to_wb_valid !== 1'b1) begin n_fail++; $display("FAIL load_valid[%0d]: got %b expected 1", i, mem_to_wb_valid); end
      e = sb.pop_front();
      n_checks++;
      if (mem_to_wb_bus !== e) begin n_fail++; $display("FAIL load_ext[%0d]: got %h expected %h", i, mem_to_wb_bus, e); end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_stall;
    logic [150:0] e;
    wb_allowin = 1'b0;
    sb.push_back(mk_wb(32'h1C000200, 1'b1, 5'd7, 32'h11223344, 1'b0, 1'b0, 14'd0, 32'd0, 32'd0, 1'b0));
    issue(mk_ex(32'h1C000200, 1'b1, 1'b1, 5'd7, 32'h20000000, 32'd0, 2'd0,
                1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 14'd0, 32'd0, 1'b0));
    data_sram_rdata = 32'h11223344;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      n_checks++;
      if (mem_allowin !== 1'b0) begin n_fail++; $display("FAIL stall_allowin[%0d]: got %b expected 0", c, mem_allowin); end
      n_checks++;
      if (mem_to_wb_valid !== 1'b1) begin n_fail++; $display("FAIL stall_valid[%0d]: got %b expected 1", c, mem_to_wb_valid); end
      @(posedge clk); #1;
      data_sram_rdata = 32'hDEADBEEF;
      // EX keeps offering a different instruction; it must not leak in.
      ex_to_mem_valid = 1'b1;
      ex_to_mem_bus   = {157{1'b1}};
    end
    ex_to_mem_valid = 1'b0;
    wb_allowin = 1'b1;
    @(negedge clk);
    n_checks++;
    if (mem_allowin !== 1'b1) begin n_fail++; $display("FAIL stall_release_allowin: got %b expected 1", mem_allowin); end
    e = sb.pop_front();
    n_checks++;
    if (mem_to_wb_bus !== e) begin n_fail++; $display("FAIL stall_data: got %h expected %h", mem_to_wb_bus, e); end
    @(posedge clk); #1;
    @(negedge clk);
    n_checks++;
    if (mem_to_wb_valid !== 1'b0) begin n_fail++; $display("FAIL stall_drained: got %b expected 0", mem_to_wb_valid); end
    @(posedge clk); #1;
  endtask

  task automatic test_flush;
    logic [150:0] e;
    // Flush against an incoming instruction.
    wb_allowin      = 1'b1;
    ex_to_mem_valid = 1'b1;
    ex_to_mem_bus   = mk_ex(32'h1C000300, 1'b0, 1'b1, 5'd9, 32'h00000009, 32'd0, 2'd0,
                            1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 14'd0, 32'd0, 1'b1);
    ertn_flush      = 1'b1;
    @(negedge clk);
    n_checks++;
    if (mem_allowin !== 1'b1) begin n_fail++; $display("FAIL flush_allowin: got %b expected 1", mem_allowin); end
    @(posedge clk); #1;
    ertn_flush      = 1'b0;
    ex_to_mem_valid = 1'b0;
    @(negedge clk);
    n_checks++;
    if (mem_to_wb_valid !== 1'b0) begin n_fail++; $display("FAIL flush_accept_valid: got %b expected 0", mem_to_wb_valid); end
    n_checks++;
    if ({mem_to_id_bus[38], mem_to_id_bus[0], mem_to_wb_bus[0]} !== 3'b000) begin
      n_fail++; $display("FAIL flush_qualified_bits: got %b expected 000", {mem_to_id_bus[38], mem_to_id_bus[0], mem_to_wb_bus[0]});
    end
    @(posedge clk); #1;
    // Flush a stalled load whose data is already held, then a fresh load must read live data.
    wb_allowin = 1'b0;
    issue(mk_ex(32'h1C000310, 1'b1, 1'b1, 5'd10, 32'h30000000, 32'd0, 2'd0,
                1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 14'd0, 32'd0, 1'b0));
    data_sram_rdata = 32'hAAAA0001;
    @(posedge clk); #1;
    data_sram_rdata = 32'hBBBB0002;
    ertn_flush = 1'b1;
    @(posedge clk); #1;
    ertn_flush = 1'b0;
    @(negedge clk);
    n_checks++;
    if (mem_to_wb_valid !== 1'b0) begin n_fail++; $display("FAIL flush_stall_valid: got %b expected 0", mem_to_wb_valid); end
    @(posedge clk); #1;
    sb.push_back(mk_wb(32'h1C000320, 1'b1, 5'd11, 32'hCCCC0003, 1'b0, 1'b0, 14'd0, 32'd0, 32'd0, 1'b0));
    issue(mk_ex(32'h1C000320, 1'b1, 1'b1, 5'd11, 32'h30000004, 32'd0, 2'd0,
                1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 14'd0, 32'd0, 1'b0));
    data_sram_rdata = 32'hCCCC0003;
    wb_allowin = 1'b1;
    @(negedge clk);
    e = sb.pop_front();
    n_checks++;
    if (mem_to_wb_bus !== e) begin n_fail++; $display("FAIL flush_then_load: got %h expected %h", mem_to_wb_bus, e); end
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back;
    logic [156:0] b [3];
    logic [150:0] x [3];
    logic [150:0] e;
    b[0] = mk_ex(32'h1C000400, 1'b0, 1'b1, 5'd5, 32'h1C000004, 32'd0, 2'd0,
                 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 14'd0, 32'd0, 1'b0);
    x[0] = mk_wb(32'h1C000400, 1'b1, 5'd5, 32'h1C000004, 1'b0, 1'b0, 14'd0, 32'd0, 32'd0, 1'b0);
    b[1] = mk_ex(32'h1C000404, 1'b0, 1'b0, 5'd0, 32'h00000000, 32'hA5A5A5A5, 2'd0,
                 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 14'h0004, 32'hFFFF0000, 1'b1);
    x[1] = mk_wb(32'h1C000404, 1'b0, 5'd0, 32'h00000000, 1'b1, 1'b1, 14'h0004, 32'hFFFF0000, 32'hA5A5A5A5, 1'b1);
    b[2] = mk_ex(32'h1C000408, 1'b0, 1'b1, 5'd31, 32'hFFFFFFFF, 32'h00000001, 2'd3,
                 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 14'd0, 32'd0, 1'b0);
    x[2] = mk_wb(32'h1C000408, 1'b1, 5'd31, 32'hFFFFFFFF, 1'b0, 1'b0, 14'd0, 32'd0, 32'h00000001, 1'b0);
    wb_allowin      = 1'b1;
    data_sram_rdata = 32'h00000055;
    ex_to_mem_valid = 1'b1;
    ex_to_mem_bus   = b[0];
    sb.push_back(x[0]);
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      if (k < 2) begin
        ex_to_mem_bus = b[k + 1];
        sb.push_back(x[k + 1]);
      end else begin
        ex_to_mem_valid = 1'b0;
      end
      @(negedge clk);
      n_checks++;
      if (mem_to_wb_valid !== 1'b1) begin n_fail++; $display("FAIL b2b_valid[%0d]: got %b expected 1", k, mem_to_wb_valid); end
      n_checks++;
      if (sb.size() == 0) begin
        n_fail++; $display("FAIL b2b_scoreboard[%0d]: got empty queue expected entry", k);
      end else begin
        e = sb.pop_front();
        if (mem_to_wb_bus !== e) begin n_fail++; $display("FAIL b2b_bus[%0d]: got %h expected %h", k, mem_to_wb_bus, e); end
      end
      if (k == 0) begin
        n_checks++;
        if (mem_to_id_bus !== {1'b1, 5'd5, 32'h1C000004, 1'b0}) begin
          n_fail++; $display("FAIL id_bus_alu: got %h expected %h", mem_to_id_bus, {1'b1, 5'd5, 32'h1C000004, 1'b0});
        end
      end
      if (k == 1) begin
        n_checks++;
        if (mem_to_id_bus !== {1'b0, 5'd0, 32'h00000000, 1'b1}) begin
          n_fail++; $display("FAIL id_bus_csr: got %h expected %h", mem_to_id_bus, {1'b0, 5'd0, 32'h00000000, 1'b1});
        end
      end
    end
    @(posedge clk); #1;
    @(negedge clk);
    n_checks++;
    if (mem_to_wb_valid !== 1'b0) begin n_fail++; $display("FAIL b2b_drained: got %b expected 0", mem_to_wb_valid); end
    n_checks++;
    if (sb.size() != 0) begin n_fail++; $display("FAIL b2b_leftover: got %0d entries expected 0", sb.size()); end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid_stall;
    logic [150:0] e;
    wb_allowin = 1'b0;
    issue(mk_ex(32'h1C000500, 1'b1, 1'b1, 5'd12, 32'h40000000, 32'd0, 2'd0,
                1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 14'd0, 32'd0, 1'b0));
    data_sram_rdata = 32'h55667788;
    @(posedge clk); #1;
    data_sram_rdata = 32'h99990000;
    @(negedge clk);
    n_checks++;
    if (mem_to_wb_valid !== 1'b1) begin n_fail++; $display("FAIL pre_reset_valid: got %b expected 1", mem_to_wb_valid); end
    #2 resetn = 1'b0;
    #1;
    n_checks++;
    if (mem_to_wb_valid !== 1'b0) begin n_fail++; $display("FAIL async_reset_valid: got %b expected 0", mem_to_wb_valid); end
    n_checks++;
    if (mem_allowin !== 1'b1) begin n_fail++; $display("FAIL async_reset_allowin: got %b expected 1", mem_allowin); end
    n_checks++;
    if (mem_to_id_bus !== 39'd0) begin n_fail++; $display("FAIL async_reset_id_bus: got %h expected 0", mem_to_id_bus); end
    @(posedge clk); #3;
    resetn = 1'b1;
    @(posedge clk); #1;
    sb.push_back(mk_wb(32'h1C000510, 1'b1, 5'd13, 32'hFFFF8123, 1'b0, 1'b0, 14'd0, 32'd0, 32'd0, 1'b0));
    issue(mk_ex(32'h1C000510, 1'b1, 1'b1, 5'd13, 32'h40000010, 32'd0, 2'd0,
                1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 14'd0, 32'd0, 1'b0));
    data_sram_rdata = 32'h00008123;
    @(posedge clk); #1;
    data_sram_rdata = 32'h00000001;
    wb_allowin = 1'b1;
    @(negedge clk);
    e = sb.pop_front();
    n_checks++;
    if (mem_to_wb_bus !== e) begin n_fail++; $display("FAIL post_reset_load: got %h expected %h", mem_to_wb_bus, e); end
    @(posedge clk); #1;
  endtask

  initial begin
    resetn          = 1'b0;
    ex_to_mem_valid = 1'b0;
    ex_to_mem_bus   = 157'd0;
    data_sram_rdata = 32'd0;
    wb_allowin      = 1'b1;
    ertn_flush      = 1'b0;
    test_reset();
    @(posedge clk); #1;
    test_load_ext();
    test_stall();
    test_flush();
    test_back_to_back();
    test_reset_mid_stall();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_stage.md
MEM_STAGE -- requirements
Module: mem_stage

Interface
REQ-001 SHALL have ports: clk  in  1  sole clock, rising edge.
REQ-002 SHALL have ports: resetn  in  1  asynchronous, active-low reset.
REQ-003 SHALL have ports: ex_to_mem_valid  in  1  EX offers an instruction.
REQ-004 SHALL have ports: ex_to_mem_bus  in  157  EX payload; field map in REQ-011.
REQ-005 SHALL have ports: mem_allowin  out  1  MEM can accept from EX this cycle.
REQ-006 SHALL have ports: data_sram_rdata  in  32  sync-SRAM read data, valid the cycle after EX issued the request.
REQ-007 SHALL have ports: wb_allowin  in  1  WB can accept.
REQ-008 SHALL have ports: mem_to_wb_valid  out  1  MEM offers an instruction to WB.
REQ-009 SHALL have ports: mem_to_wb_bus  out  151  {pc32, rf_we1, rf_waddr5, rf_wdata32, csr_re1, csr_we1, csr_num14, csr_wmask32, csr_wdata32, ertn_flush1}, MSB first.
REQ-010 SHALL have ports: mem_to_id_bus  out  39  {rf_we&valid, rf_waddr5, rf_wdata32, csr_re&valid}; ertn_flush  in  1  pipeline flush from WB.

Function
REQ-011 ex_to_mem_bus SHALL decode as: [156:125] pc, [124] res_from_mem, [123] rf_we, [122:118] rf_waddr, [117:86] alu_result, [85:54] rkd_value, [53:52] addr_lo, [51] op_b, [50] op_h, [49] op_u, [48] csr_re, [47] csr_we, [46:33] csr_num, [32:1] csr_wmask, [0] ertn_flush.
REQ-012 mem_ready_go SHALL be 1 in every cycle.
REQ-013 mem_allowin SHALL equal ~mem_valid | (mem_ready_go & wb_allowin).
REQ-014 mem_to_wb_valid SHALL equal mem_valid & mem_ready_go.
REQ-015 On a clk edge with ertn_flush=1, mem_valid SHALL become 0; flush SHALL take priority over acceptance.
REQ-016 Otherwise, when mem_allowin=1, mem_valid SHALL load ex_to_mem_valid.
REQ-017 The payload register SHALL load ex_to_mem_bus only when ex_to_mem_valid & mem_allowin; it SHALL hold its value otherwise.
REQ-018 Read-data capture: in the first cycle after acceptance, data_sram_rdata SHALL be latched into rdata_hold and a hold flag SHALL be set.
REQ-019 The hold flag SHALL clear when the instruction leaves (wb_allowin=1) or on flush; load data SHALL come from data_sram_rdata while the flag is 0 and from rdata_hold while it is 1, so stalls never corrupt the value.
REQ-020 Load extension, with byte = rdata >> (8*addr_lo): op_b & ~op_u -> sign-extend byte[7:0]; op_b & op_u -> zero-extend byte[7:0].
REQ-021 Load extension, halfword: op_h selects rdata[31:16] when addr_lo[1]=1, else rdata[15:0]; sign-extend when ~op_u, zero-extend when op_u; neither op_b nor op_h -> full word.
REQ-022 rf_wdata SHALL be the extended load value when res_from_mem=1, else alu_result.
REQ-023 csr_wdata SHALL be rkd_value; csr_re, csr_we, csr_num, csr_wmask and ertn_flush SHALL pass through unchanged.
REQ-024 rf_we, csr_re and ertn_flush in mem_to_wb_bus, and both valid-qualified bits in mem_to_id_bus, SHALL be ANDed with mem_valid.
REQ-025 Path from data_sram_rdata to rf_wdata SHALL be combinational, with zero added latency.

Reset
REQ-026 While resetn=0, regardless of clk, mem_valid, the payload register, rdata_hold and the hold flag SHALL be 0.
REQ-027 During reset, outputs SHALL be: mem_allowin=1, mem_to_wb_valid=0, and every valid-qualified bus bit 0.
REQ-028 Asserting reset mid-stall SHALL discard the held instruction; after release, the first accepted instruction SHALL behave as in REQ-018.

Verification
REQ-029 ld.b, addr_lo=2, rdata=0x12F45678, op_u=0 -> rf_wdata=0xFFFFFFF4; same with op_u=1 -> 0x000000F4.
REQ-030 ld.h, addr_lo=2, rdata=0x8001_7FFF, op_u=0 -> rf_wdata=0xFFFF8001; ld.w -> 0x80017FFF.
REQ-031 Load accepted with wb_allowin=0 for 3 cycles; rdata changes to 0xDEADBEEF after the first cycle -> WB receives the first-cycle value; mem_allowin=0 throughout the stall.
REQ-032 ertn_flush pulsed while ex_to_mem_valid=1 and mem_allowin=1 -> mem_valid=0 on the next cycle, with no WB handoff.
REQ-033 Non-load instruction with alu_result=0x1C000004, rf_we=1, rf_waddr=5 -> mem_to_id_bus={1,5,0x1C000004,0}.
REQ-034 resetn=0 asserted between clk edges while mem_valid=1 -> mem_to_wb_valid=0 immediately.
